// File: rtl/matrix_transpose_stream_pkg.sv
// Shared widths and helpers for the streaming matrix transposer.
`timescale 1ns/1ps
package transpose_pkg;

    localparam int unsigned DEF_M          = 32'd2;
    localparam int unsigned DEF_N          = 32'd2;
    localparam int unsigned DEF_DATA_WIDTH = 32'd8;

    // A zero-width counter is illegal, so single-entry ranges still get one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        return (value > 32'd1) ? $clog2(value) : 32'd1;
    endfunction

    localparam int unsigned DEF_ROW_W  = clog2_min1(DEF_M);
    localparam int unsigned DEF_COL_W  = clog2_min1(DEF_N);
    localparam int unsigned DEF_ADDR_W = clog2_min1(DEF_M * DEF_N);

endpackage

// File: rtl/matrix_transpose_stream_if.sv
// Element stream bundle: input handshake plus transposed output handshake.
`timescale 1ns/1ps
interface matrix_transpose_stream_if
    import transpose_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix_transpose_stream_bank.sv
// One matrix bank: register array with a single write port and a combinational read mux.
`timescale 1ns/1ps
module transpose_bank
    import transpose_pkg::*;
#(
    parameter int unsigned DEPTH      = DEF_M * DEF_N,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_W     = clog2_min1(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Element storage; contents deliberately survive reset, validity is tracked by the full flags.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read mux, guarded for depths that are not a power of two.
    always_comb begin
        if (32'(raddr_i) < DEPTH) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = {DATA_WIDTH{1'b0}};
        end
    end
endmodule

// File: rtl/matrix_transpose_stream.sv
// Ping-pong streaming transposer: row-major M x N in, row-major N x M out, one element per cycle.
`timescale 1ns/1ps
module matrix_transpose_stream
    import transpose_pkg::*;
#(
    parameter int unsigned M          = DEF_M,
    parameter int unsigned N          = DEF_N,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    matrix_transpose_stream_if.slave bus_io
);
    localparam int unsigned ROW_W  = clog2_min1(M);
    localparam int unsigned COL_W  = clog2_min1(N);
    localparam int unsigned DEPTH  = M * N;
    localparam int unsigned ADDR_W = clog2_min1(DEPTH);

    localparam logic [ROW_W-1:0]  ROW_MAX = ROW_W'(M - 32'd1);
    localparam logic [COL_W-1:0]  COL_MAX = COL_W'(N - 32'd1);
    localparam logic [ADDR_W-1:0] N_ADDR  = ADDR_W'(N);

    logic [1:0]       full_q,   full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [ROW_W-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;

    logic                  in_ready_s, out_valid_s, out_last_s;
    logic                  wr_fire_s, rd_fire_s, wr_last_s;
    logic [ADDR_W-1:0]     wr_addr_s, rd_addr_s;
    logic [DATA_WIDTH-1:0] rdata0_s, rdata1_s, out_data_s;

    assign in_ready_s  = ~full_q[wr_sel_q];
    assign out_valid_s = full_q[rd_sel_q];
    assign wr_fire_s   = bus_io.in_valid & in_ready_s;
    assign rd_fire_s   = out_valid_s & bus_io.out_ready;
    assign wr_last_s   = (wr_row_q == ROW_MAX) && (wr_col_q == COL_MAX);
    assign out_last_s  = out_valid_s && (rd_row_q == ROW_MAX) && (rd_col_q == COL_MAX);

    // Both sides address the bank in row-major layout; only the counter nesting differs.
    assign wr_addr_s = ADDR_W'(wr_row_q) * N_ADDR + ADDR_W'(wr_col_q);
    assign rd_addr_s = ADDR_W'(rd_row_q) * N_ADDR + ADDR_W'(rd_col_q);

    transpose_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk(clk), .we_i(wr_fire_s & ~wr_sel_q), .waddr_i(wr_addr_s),
        .wdata_i(bus_io.in_data), .raddr_i(rd_addr_s), .rdata_o(rdata0_s)
    );

    transpose_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clk(clk), .we_i(wr_fire_s & wr_sel_q), .waddr_i(wr_addr_s),
        .wdata_i(bus_io.in_data), .raddr_i(rd_addr_s), .rdata_o(rdata1_s)
    );

    // Next-state control; set and clear of full flags always hit different banks.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        rd_row_d = rd_row_q;
        rd_col_d = rd_col_q;
        if (wr_fire_s) begin
            if (wr_last_s) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
                wr_row_d         = '0;
                wr_col_d         = '0;
            end else if (wr_col_q == COL_MAX) begin
                wr_col_d = '0;
                wr_row_d = wr_row_q + ROW_W'(1'b1);
            end else begin
                wr_col_d = wr_col_q + COL_W'(1'b1);
            end
        end else begin
            wr_sel_d = wr_sel_q;
        end
        if (rd_fire_s) begin
            if (out_last_s) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
                rd_row_d         = '0;
                rd_col_d         = '0;
            end else if (rd_row_q == ROW_MAX) begin
                rd_row_d = '0;
                rd_col_d = rd_col_q + COL_W'(1'b1);
            end else begin
                rd_row_d = rd_row_q + ROW_W'(1'b1);
            end
        end else begin
            rd_sel_d = rd_sel_q;
        end
    end

    // Control state with synchronous reset that discards every buffered matrix.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full_q   <= 2'b00;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_row_q <= '0;
            wr_col_q <= '0;
            rd_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_row_q <= wr_row_d;
            wr_col_q <= wr_col_d;
            rd_row_q <= rd_row_d;
            rd_col_q <= rd_col_d;
        end
    end

    // Output element selection from the bank being drained.
    always_comb begin
        if (rd_sel_q) begin
            out_data_s = rdata1_s;
        end else begin
            out_data_s = rdata0_s;
        end
    end

    assign bus_io.in_ready  = in_ready_s;
    assign bus_io.out_valid = out_valid_s;
    assign bus_io.out_data  = out_data_s;
    assign bus_io.out_last  = out_last_s;
endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Scoreboard bench: three transposer shapes (2x3, 3x4, 1x4) driven with directed and stalled streams.
`timescale 1ns/1ps
module tb_matrix_transpose_stream;
    import transpose_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic b_done = 1'b0;
    int   lasts_b = 0;

    logic [8:0] exp_a[$];
    logic [8:0] exp_b[$];
    logic [8:0] exp_c[$];
    int         out_cyc_a[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    matrix_transpose_stream_if #(.DATA_WIDTH(8)) if_a();
    matrix_transpose_stream_if #(.DATA_WIDTH(8)) if_b();
    matrix_transpose_stream_if #(.DATA_WIDTH(8)) if_c();

    matrix_transpose_stream #(.M(2), .N(3), .DATA_WIDTH(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus_io(if_a));
    matrix_transpose_stream #(.M(3), .N(4), .DATA_WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus_io(if_b));
    matrix_transpose_stream #(.M(1), .N(4), .DATA_WIDTH(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus_io(if_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input int which);
        case (which)
            0:       return if_a.in_ready;
            1:       return if_b.in_ready;
            default: return if_c.in_ready;
        endcase
    endfunction

    task automatic set_in(input int which, input logic v, input logic [7:0] d);
        case (which)
            0:       begin if_a.in_valid = v; if_a.in_data = d; end
            1:       begin if_b.in_valid = v; if_b.in_data = d; end
            default: begin if_c.in_valid = v; if_c.in_data = d; end
        endcase
    endtask

    // Offer one element and return once it has been accepted (or the bound expires).
    task automatic push(input int which, input logic [7:0] d, output int stalls);
        int n;
        n = 0;
        set_in(which, 1'b1, d);
        @(negedge clk);
        while (!rdy(which) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL push_timeout dut%0d: in_ready low for %0d cycles, required accept", which, n);
        end
        @(posedge clk);
        #1;
        set_in(which, 1'b0, d);
        stalls = n;
    endtask

    task automatic wait_empty(input int which, input string name);
        int n;
        int left;
        n = 0;
        left = 1;
        while (left != 0 && n < 3000) begin
            @(negedge clk);
            n++;
            case (which)
                0:       left = exp_a.size();
                1:       left = exp_b.size();
                default: left = exp_c.size();
            endcase
        end
        check(name, 32'(left), 32'd0);
    endtask

    // Monitor for the 2x3 instance.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (!if_a.out_valid) check("a_last_idle", 32'(if_a.out_last), 32'd0);
            if (if_a.out_valid && if_a.out_ready) begin
                out_cyc_a.push_back(cyc);
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected: got data %0d, expected no output", if_a.out_data);
                end else begin
                    e = exp_a.pop_front();
                    check("a_data", 32'(if_a.out_data), 32'(e[7:0]));
                    check("a_last", 32'(if_a.out_last), 32'(e[8]));
                end
            end
        end
    end

    // Monitor for the 3x4 instance, including hold-stable checks under backpressure.
    logic       hold_b = 1'b0;
    logic [8:0] hold_val_b = 9'd0;
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                check("b_hold_valid", 32'(if_b.out_valid), 32'd1);
                check("b_hold_data", 32'({if_b.out_last, if_b.out_data}), 32'(hold_val_b));
            end
            if (if_b.out_valid && if_b.out_ready) begin
                if (if_b.out_last) lasts_b++;
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected: got data %0d, expected no output", if_b.out_data);
                end else begin
                    e = exp_b.pop_front();
                    check("b_data", 32'(if_b.out_data), 32'(e[7:0]));
                    check("b_last", 32'(if_b.out_last), 32'(e[8]));
                end
            end
            hold_b = if_b.out_valid && !if_b.out_ready;
            hold_val_b = {if_b.out_last, if_b.out_data};
        end
    end

    // Monitor for the 1x4 instance.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n && if_c.out_valid && if_c.out_ready) begin
            if (exp_c.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL c_unexpected: got data %0d, expected no output", if_c.out_data);
            end else begin
                e = exp_c.pop_front();
                check("c_data", 32'(if_c.out_data), 32'(e[7:0]));
                check("c_last", 32'(if_c.out_last), 32'(e[8]));
            end
        end
    end

    // Random consumer for the 3x4 instance.
    initial begin
        @(posedge b_done or posedge clk);
        while (!b_done) begin
            @(posedge clk);
            #1;
            if (!b_done) if_b.out_ready = 1'($urandom_range(1));
        end
        if_b.out_ready = 1'b1;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int st;
        int tot;
        int mat_a[6];
        int tr_a[6];
        int last_idx;
        if_a.in_valid = 1'b0; if_a.in_data = 8'd0; if_a.out_ready = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = 8'd0; if_b.out_ready = 1'b0;
        if_c.in_valid = 1'b0; if_c.in_data = 8'd0; if_c.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_a_out_valid", 32'(if_a.out_valid), 32'd0);
        check("rst_a_out_last", 32'(if_a.out_last), 32'd0);
        check("rst_a_in_ready", 32'(if_a.in_ready), 32'd1);
        check("rst_b_in_ready", 32'(if_b.in_ready), 32'd1);
        check("rst_c_out_valid", 32'(if_c.out_valid), 32'd0);

        // Basic order on 2x3: 1..6 -> 1,4,2,5,3,6 and first out_valid right after the last accept.
        @(posedge clk); #1;
        if_a.out_ready = 1'b1;
        tr_a = '{1, 4, 2, 5, 3, 6};
        foreach (tr_a[i]) exp_a.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(tr_a[i])});
        for (int i = 1; i <= 5; i++) push(0, 8'(i), st);
        @(negedge clk);
        check("a_valid_before_last", 32'(if_a.out_valid), 32'd0);
        @(posedge clk); #1;
        push(0, 8'd6, st);
        @(negedge clk);
        check("a_latency_valid", 32'(if_a.out_valid), 32'd1);
        wait_empty(0, "a_basic_drain");

        // Back-to-back: two matrices, no input stalls, twelve outputs in twelve consecutive cycles.
        @(posedge clk); #1;
        out_cyc_a.delete();
        tr_a = '{1, 4, 2, 5, 3, 6};
        foreach (tr_a[i]) exp_a.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(tr_a[i])});
        tr_a = '{11, 14, 12, 15, 13, 16};
        foreach (tr_a[i]) exp_a.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(tr_a[i])});
        mat_a = '{1, 2, 3, 4, 5, 6};
        tot = 0;
        foreach (mat_a[i]) begin push(0, 8'(mat_a[i]), st); tot += st; end
        mat_a = '{11, 12, 13, 14, 15, 16};
        foreach (mat_a[i]) begin push(0, 8'(mat_a[i]), st); tot += st; end
        check("a_b2b_in_stalls", 32'(tot), 32'd0);
        wait_empty(0, "a_b2b_drain");
        check("a_b2b_out_count", 32'(out_cyc_a.size()), 32'd12);
        last_idx = out_cyc_a.size() - 1;
        if (last_idx >= 0) check("a_b2b_gapless", 32'(out_cyc_a[last_idx] - out_cyc_a[0]), 32'd11);

        // Backpressure: both banks fill, third matrix waits, first output held at 1.
        @(posedge clk); #1;
        if_a.out_ready = 1'b0;
        tr_a = '{1, 4, 2, 5, 3, 6};
        foreach (tr_a[i]) exp_a.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(tr_a[i])});
        tr_a = '{11, 14, 12, 15, 13, 16};
        foreach (tr_a[i]) exp_a.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(tr_a[i])});
        tr_a = '{31, 34, 32, 35, 33, 36};
        foreach (tr_a[i]) exp_a.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(tr_a[i])});
        for (int i = 1; i <= 6; i++) push(0, 8'(i), st);
        for (int i = 11; i <= 16; i++) push(0, 8'(i), st);
        set_in(0, 1'b1, 8'd31);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("a_bp_in_ready", 32'(if_a.in_ready), 32'd0);
            check("a_bp_out_valid", 32'(if_a.out_valid), 32'd1);
            check("a_bp_out_data", 32'(if_a.out_data), 32'd1);
        end
        @(posedge clk); #1;
        if_a.out_ready = 1'b1;
        for (int i = 31; i <= 36; i++) push(0, 8'(i), st);
        wait_empty(0, "a_bp_drain");

        // Reset mid-fill: partial matrix discarded, fresh matrix transposes cleanly.
        @(posedge clk); #1;
        for (int i = 41; i <= 44; i++) push(0, 8'(i), st);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("a_rst_out_valid", 32'(if_a.out_valid), 32'd0);
        check("a_rst_in_ready", 32'(if_a.in_ready), 32'd1);
        @(posedge clk); #1;
        tr_a = '{21, 24, 22, 25, 23, 26};
        foreach (tr_a[i]) exp_a.push_back({(i == 5) ? 1'b1 : 1'b0, 8'(tr_a[i])});
        for (int i = 21; i <= 26; i++) push(0, 8'(i), st);
        wait_empty(0, "a_rst_drain");
        repeat (3) @(negedge clk);
        check("a_rst_idle_valid", 32'(if_a.out_valid), 32'd0);

        // Degenerate 1x4: order preserved, out_last with 10.
        @(posedge clk); #1;
        if_c.out_ready = 1'b1;
        exp_c.push_back({1'b0, 8'd7});
        exp_c.push_back({1'b0, 8'd8});
        exp_c.push_back({1'b0, 8'd9});
        exp_c.push_back({1'b1, 8'd10});
        for (int i = 7; i <= 10; i++) push(2, 8'(i), st);
        wait_empty(2, "c_drain");

        // Random stalls on 3x4 over 50 matrices, consumer randomised by its own process.
        @(posedge clk); #1;
        for (int m = 0; m < 50; m++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 3; r++)
                    exp_b.push_back({(r == 2 && c == 3) ? 1'b1 : 1'b0, 8'(m * 12 + r * 4 + c)});
            for (int e = 0; e < 12; e++) begin
                if ($urandom_range(3) == 32'd0) begin @(posedge clk); #1; end
                push(1, 8'(m * 12 + e), st);
            end
        end
        wait_empty(1, "b_drain");
        b_done = 1'b1;
        check("b_last_count", 32'(lasts_b), 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
